// File: rtl/product_accumulator.sv
// product_accumulator: sums N multiplier products per result, saturating, with valid/ready handshakes
module product_accumulator #(
  parameter int PW = 6,
  parameter int AW = 8,
  parameter int N  = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [PW-1:0] in_p,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] sum,
  output logic          ovf,
  output logic [CW-1:0] count
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] sum_q, sum_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW:0]   t;
  logic          acc, done;
  always_comb begin
    acc     = state_q == ACC && in_valid;
    done    = state_q == HOLD && out_ready;
    t       = {1'b0, sum_q} + {{(AW + 1 - PW){1'b0}}, in_p};
    sum_d   = done ? '0 : acc ? (t[AW] ? '1 : t[AW-1:0]) : sum_q;
    ovf_d   = done ? 1'b0 : ovf_q | (acc & t[AW]);
    count_d = done ? '0 : acc ? count_q + CW'(1) : count_q;
    state_d = done ? ACC : (acc && count_q == CW'(N - 1)) ? HOLD : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end
  assign in_ready  = state_q == ACC;
  assign out_valid = state_q == HOLD;
  assign sum       = sum_q;
  assign ovf       = ovf_q;
  assign count     = count_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed checks of an N=4 and an N=8 accumulator
module tb_product_accumulator;
  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_ready, a_in_ready, a_out_valid, a_ovf;
  logic [5:0] a_p;
  logic [7:0] a_sum;
  logic [2:0] a_count;
  logic       b_valid, b_ready, b_in_ready, b_out_valid, b_ovf;
  logic [5:0] b_p;
  logic [7:0] b_sum;
  logic [3:0] b_count;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  product_accumulator #(.PW(6), .AW(8), .N(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_p(a_p), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(a_ready), .sum(a_sum), .ovf(a_ovf), .count(a_count));
  product_accumulator #(.PW(6), .AW(8), .N(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_p(b_p), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_ready), .sum(b_sum), .ovf(b_ovf), .count(b_count));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input int s, input int o, input int c, input int ov, input int ir);
    chk({tag, ".sum"}, 32'(a_sum), s);
    chk({tag, ".ovf"}, 32'(a_ovf), o);
    chk({tag, ".count"}, 32'(a_count), c);
    chk({tag, ".out_valid"}, 32'(a_out_valid), ov);
    chk({tag, ".in_ready"}, 32'(a_in_ready), ir);
  endtask
  task automatic feed_a(input int p);
    a_valid = 1'b1;
    a_p = 6'(p);
    tick;
  endtask
  initial begin
    int exp_sum;
    int exp_ovf;
    rst = 1'b1;
    a_valid = 1'b1; a_p = 6'd49; a_ready = 1'b0;
    b_valid = 1'b1; b_p = 6'd49; b_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk_a("reset", 0, 0, 0, 0, 1);
    tick;
    chk_a("reset_idle", 0, 0, 0, 0, 1);
    chk("reset_b.sum", 32'(b_sum), 0);
    // basic dot product 10+49+0+12
    a_ready = 1'b1;
    feed_a(10);
    chk_a("basic1", 10, 0, 1, 0, 1);
    feed_a(49);
    chk_a("basic2", 59, 0, 2, 0, 1);
    feed_a(0);
    chk_a("basic3", 59, 0, 3, 0, 1);
    feed_a(12);
    a_valid = 1'b0;
    chk_a("basic_hold", 71, 0, 4, 1, 0);
    tick;
    chk_a("basic_exit", 0, 0, 0, 0, 1);
    // backpressure, with a term of 7 offered during HOLD
    a_ready = 1'b0;
    feed_a(10);
    feed_a(49);
    feed_a(0);
    feed_a(12);
    a_p = 6'd7;
    for (int i = 0; i < 5; i++) begin
      chk_a("bp_hold", 71, 0, 4, 1, 0);
      tick;
    end
    a_ready = 1'b1;
    chk_a("bp_hold_last", 71, 0, 4, 1, 0);
    tick;
    chk_a("bp_exit", 0, 0, 0, 0, 1);
    tick;
    chk_a("bp_take7", 7, 0, 1, 0, 1);
    feed_a(0);
    feed_a(0);
    feed_a(0);
    a_valid = 1'b0;
    chk_a("bp_second", 7, 0, 4, 1, 0);
    tick;
    // gapped input 3,4,5,6
    feed_a(3);
    chk_a("gap1", 3, 0, 1, 0, 1);
    a_valid = 1'b0;
    tick;
    chk_a("gap1_idle", 3, 0, 1, 0, 1);
    feed_a(4);
    chk_a("gap2", 7, 0, 2, 0, 1);
    a_valid = 1'b0;
    tick;
    feed_a(5);
    chk_a("gap3", 12, 0, 3, 0, 1);
    a_valid = 1'b0;
    tick;
    chk_a("gap3_idle", 12, 0, 3, 0, 1);
    feed_a(6);
    a_valid = 1'b0;
    chk_a("gap_done", 18, 0, 4, 1, 0);
    tick;
    // mid-operation reset
    feed_a(49);
    feed_a(49);
    chk_a("mid_partial", 98, 0, 2, 0, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    a_valid = 1'b0;
    chk_a("mid_reset", 0, 0, 0, 0, 1);
    feed_a(1);
    feed_a(1);
    feed_a(1);
    feed_a(1);
    a_valid = 1'b0;
    chk_a("mid_done", 4, 0, 4, 1, 0);
    tick;
    // saturation on the N=8 instance
    exp_sum = 0;
    exp_ovf = 0;
    b_valid = 1'b1;
    b_p = 6'd49;
    for (int i = 1; i <= 8; i++) begin
      tick;
      exp_sum += 49;
      if (exp_sum > 255) begin
        exp_sum = 255;
        exp_ovf = 1;
      end
      chk("sat.sum", 32'(b_sum), exp_sum);
      chk("sat.ovf", 32'(b_ovf), exp_ovf);
      chk("sat.count", 32'(b_count), i);
    end
    b_valid = 1'b0;
    chk("sat.out_valid", 32'(b_out_valid), 1);
    chk("sat.sum_final", 32'(b_sum), 255);
    b_ready = 1'b1;
    tick;
    chk("sat_exit.sum", 32'(b_sum), 0);
    chk("sat_exit.ovf", 32'(b_ovf), 0);
    chk("sat_exit.in_ready", 32'(b_in_ready), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
